// File: rtl/gray_code_pipe.sv
// gray_code_pipe: pipelined bidirectional Gray/binary converter with a
// valid/ready handshake on both sides and a Gray pointer step-integrity check.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      input beat valid
//   in_ready      block can accept an input beat (combinational from out_ready)
//   in_mode       0 = binary->Gray, 1 = Gray->binary
//   in_data       value to convert
//   out_valid     output beat valid
//   out_ready     downstream accepts the output beat
//   out_data      converted value
//   out_mode      in_mode carried with the beat
//   out_step_err  beat's Gray input differed from the previous Gray input in >1 bit
//   err_count     saturating count of delivered step-error beats
module gray_code_pipe #(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [SIZE-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SIZE-1:0]  out_data,
   output logic             out_mode,
   output logic             out_step_err,
   output logic [CNT_W-1:0] err_count
);

   typedef struct packed {
      logic            mode;
      logic            step_err;
      logic [SIZE-1:0] data;
   } beat_t;

   beat_t             slot_q [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] ld;
   logic [SIZE-1:0]   hist_q;
   logic              hist_valid_q;
   logic [CNT_W-1:0]  err_count_q;

   logic [SIZE-1:0]   conv;
   logic [SIZE-1:0]   diff;
   logic              acc;
   logic              step_err;
   beat_t             in_beat;

   // Conversion is done fully at the input so every slot already holds the
   // exact result; the later stages are pure retiming.
   always_comb begin
      conv = '0;
      acc  = 1'b0;
      if (!in_mode) begin
         conv = in_data ^ (in_data >> 1);
      end else begin
         for (int i = int'(SIZE) - 1; i >= 0; i--) begin
            acc     = acc ^ in_data[i];
            conv[i] = acc;
         end
      end
   end

   // More than one differing bit <=> clearing the lowest set bit leaves a residue.
   always_comb begin
      diff     = in_data ^ hist_q;
      step_err = in_mode && hist_valid_q && (|(diff & (diff - SIZE'(1))));
   end

   always_comb begin
      in_beat          = '0;
      in_beat.mode     = in_mode;
      in_beat.step_err = step_err;
      in_beat.data     = conv;
   end

   // Slot k may load when it is empty or its occupant moves on this cycle.
   always_comb begin
      ld = '0;
      ld[STAGES-1] = !valid_q[STAGES-1] || out_ready;
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
         ld[k] = !valid_q[k] || ld[k+1];
      end
   end

   assign in_ready = ld[0];

   // Pipeline slots, Gray history and error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         for (int k = 0; k < int'(STAGES); k++) begin
            slot_q[k] <= '0;
         end
         hist_q       <= '0;
         hist_valid_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         if (ld[0]) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
               slot_q[0] <= in_beat;
            end
         end
         for (int k = 1; k < int'(STAGES); k++) begin
            if (ld[k]) begin
               valid_q[k] <= valid_q[k-1];
               if (valid_q[k-1]) begin
                  slot_q[k] <= slot_q[k-1];
               end
            end
         end
         if (in_valid && ld[0] && in_mode) begin
            hist_q       <= in_data;
            hist_valid_q <= 1'b1;
         end
         if (valid_q[STAGES-1] && out_ready && slot_q[STAGES-1].step_err &&
             (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
         end
      end
   end

   assign out_valid    = valid_q[STAGES-1];
   assign out_data     = slot_q[STAGES-1].data;
   assign out_mode     = slot_q[STAGES-1].mode;
   assign out_step_err = slot_q[STAGES-1].step_err;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_gray_code_pipe.sv
// tb_gray_code_pipe: directed plus randomized checks of gray_code_pipe against
// a queue-based transaction model (SIZE=4, STAGES=2, CNT_W=2).
module tb_gray_code_pipe;

   localparam int unsigned SIZE   = 4;
   localparam int unsigned STAGES = 2;
   localparam int unsigned CNT_W  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [SIZE-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [SIZE-1:0]  out_data;
   logic             out_mode;
   logic             out_step_err;
   logic [CNT_W-1:0] err_count;

   gray_code_pipe #(.SIZE(SIZE), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mode      (in_mode),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_mode     (out_mode),
      .out_step_err (out_step_err),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SIZE-1:0] data;
      logic            mode;
      logic            err;
      int              a;
   } exp_t;

   exp_t            q[$];
   logic [SIZE-1:0] m_hist;
   bit              m_hist_v;
   int              m_cnt;
   int              edge_n;
   bit              armed;
   int              checks;
   int              failures;

   logic [3:0] sweep [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

   // Gray->binary by searching for the binary value whose Gray code matches.
   function automatic logic [SIZE-1:0] ref_conv(logic m, logic [SIZE-1:0] v);
      logic [SIZE-1:0] bb;
      if (!m) return v ^ (v >> 1);
      for (int b = 0; b < (1 << SIZE); b++) begin
         bb = SIZE'(b);
         if ((bb ^ (bb >> 1)) == v) return bb;
      end
      return '0;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, check outputs before the edge, then advance the model.
   task automatic tick(bit r, bit v, bit m, logic [SIZE-1:0] d, bit ordy);
      bit   exp_ov;
      bit   exp_ir;
      exp_t e;
      rst       = r;
      in_valid  = v;
      in_mode   = m;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      exp_ov = (q.size() > 0) && (edge_n >= q[0].a + int'(STAGES) - 1);
      exp_ir = ordy || (q.size() < int'(STAGES));
      if (armed) begin
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         check("in_ready",  32'(in_ready),  32'(exp_ir));
         check("err_count", 32'(err_count), 32'(m_cnt));
         if (exp_ov) begin
            check("out_data",     32'(out_data),     32'(q[0].data));
            check("out_mode",     32'(out_mode),     32'(q[0].mode));
            check("out_step_err", 32'(out_step_err), 32'(q[0].err));
         end
      end
      @(posedge clk);
      edge_n++;
      if (r) begin
         q.delete();
         m_hist   = '0;
         m_hist_v = 1'b0;
         m_cnt    = 0;
         armed    = 1'b1;
      end else begin
         if (exp_ov && ordy) begin
            if (q[0].err && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
            void'(q.pop_front());
         end
         if (v && exp_ir) begin
            e.data = ref_conv(m, d);
            e.mode = m;
            e.err  = m && m_hist_v && ($countones(d ^ m_hist) > 1);
            e.a    = edge_n;
            q.push_back(e);
            if (m) begin
               m_hist   = d;
               m_hist_v = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      logic [SIZE-1:0] g;
      logic [SIZE-1:0] prev_g;
      bit              r;
      bit              v;
      bit              m;
      checks    = 0;
      failures  = 0;
      edge_n    = 0;
      armed     = 1'b0;
      m_cnt     = 0;
      m_hist    = '0;
      m_hist_v  = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_mode   = 1'b1;
      in_data   = 4'h5;
      out_ready = 1'b1;

      // Reset held two cycles with a valid input present.
      tick(1'b1, 1'b1, 1'b1, 4'h5, 1'b1);
      tick(1'b1, 1'b1, 1'b1, 4'h5, 1'b1);
      check("rst_out_valid", 32'(out_valid),    32'd0);
      check("rst_in_ready",  32'(in_ready),     32'd1);
      check("rst_out_data",  32'(out_data),     32'd0);
      check("rst_out_mode",  32'(out_mode),     32'd0);
      check("rst_step_err",  32'(out_step_err), 32'd0);
      check("rst_err_count", 32'(err_count),    32'd0);
      idle(3);

      // Gray->binary sweep including the 8->0 wrap.
      for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 1'b1, sweep[i], 1'b1);
      idle(3);
      check("sweep_err_count", 32'(err_count), 32'd0);

      // Step error 0->3 flagged, then 3->2 legal.
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 4'h3, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 4'h2, 1'b1);
      idle(3);
      check("step_err_count", 32'(err_count), 32'd1);

      // Binary->Gray interleaved with large Gray jumps.
      tick(1'b0, 1'b1, 1'b0, 4'hB, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 4'hD, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 4'h5, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 4'hF, 1'b1);
      idle(3);

      // Backpressure: continuous Gray input, out_ready low for 6 cycles.
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         g = SIZE'(i) ^ (SIZE'(i) >> 1);
         tick(1'b0, 1'b1, 1'b1, g, !(i >= 2 && i < 8));
      end
      idle(4);

      // Saturation: five step-error beats with a 2-bit counter.
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 4'h0 : 4'h3, 1'b1);
      idle(4);
      check("sat_err_count", 32'(err_count), 32'd3);

      // Mid-stream reset with two beats in flight, then an unflagged Gray beat.
      tick(1'b0, 1'b1, 1'b1, 4'h6, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 4'h9, 1'b1);
      tick(1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_err_count", 32'(err_count), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 4'hA, 1'b1);
      idle(3);

      // Randomized traffic with occasional resets.
      prev_g = '0;
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 249) == 0);
         v = ($urandom_range(0, 3) != 0);
         m = $urandom_range(0, 1) == 1;
         if (m && ($urandom_range(0, 4) != 0))
            g = prev_g ^ (($urandom_range(0, 1) == 1) ? SIZE'(1 << $urandom_range(0, SIZE - 1)) : '0);
         else
            g = SIZE'($urandom_range(0, (1 << SIZE) - 1));
         if (m) prev_g = g;
         tick(r, v, m, g, $urandom_range(0, 9) < 7);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
